// File: rtl/ofs_plat_axi_mem_rd_rsp_buffer.sv
// Read-response landing buffer: absorbs device read beats without backpressure
// and replays them under valid/ready through a RAM -> prefetch -> output pipeline.
module ofs_plat_axi_mem_rd_rsp_buffer #(
  parameter int N_ENTRIES   = 256,
  parameter int N_DATA_BITS = 512
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  input  logic [N_DATA_BITS-1:0]         in_data,
  output logic                           out_valid,
  output logic [N_DATA_BITS-1:0]         out_data,
  input  logic                           out_ready,
  output logic [$clog2(N_ENTRIES+1)-1:0] occupancy,
  output logic [$clog2(N_ENTRIES+1)-1:0] max_occupancy,
  output logic                           overflow_err
);

  localparam int DEPTH = N_ENTRIES - 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N_ENTRIES + 1);
  localparam logic [CW-1:0] FULL = CW'(N_ENTRIES);

  logic [N_DATA_BITS-1:0] mem [DEPTH];

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          ram_cnt_q, ram_cnt_d;
  logic [CW-1:0]          occ_q, occ_d, max_q, max_d;
  logic                   pf_valid_q, pf_valid_d, out_valid_q, out_valid_d;
  logic                   ovf_q, ovf_d;
  logic [N_DATA_BITS-1:0] pf_data_q, pf_data_d, out_data_q, out_data_d;

  logic out_fire, full, in_accept, drop, out_load, pf_load;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    out_fire  = out_valid_q && out_ready;
    full      = (occ_q == FULL);
    in_accept = in_valid && (!full || out_fire);
    drop      = in_valid && full && !out_fire;
    out_load  = pf_valid_q && (!out_valid_q || out_ready);
    // The RAM's registered read port is the prefetch stage; it refills
    // whenever prefetch is empty or handing its beat to the output stage.
    pf_load   = (ram_cnt_q != '0) && (!pf_valid_q || out_load);

    wr_ptr_d    = in_accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pf_load   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ram_cnt_d   = ram_cnt_q + CW'(in_accept) - CW'(pf_load);
    pf_valid_d  = pf_load  || (pf_valid_q  && !out_load);
    out_valid_d = out_load || (out_valid_q && !out_fire);
    pf_data_d   = pf_load  ? mem[rd_ptr_q] : pf_data_q;
    out_data_d  = out_load ? pf_data_q     : out_data_q;

    occ_d = occ_q;
    if (in_accept && !out_fire)      occ_d = occ_q + 1'b1;
    else if (!in_accept && out_fire) occ_d = occ_q - 1'b1;

    max_d = (occ_d > max_q) ? occ_d : max_q;
    ovf_d = ovf_q || drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      occ_q       <= '0;
      max_q       <= '0;
      pf_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      occ_q       <= occ_d;
      max_q       <= max_d;
      pf_valid_q  <= pf_valid_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Payload storage carries no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (in_accept) mem[wr_ptr_q] <= in_data;
    pf_data_q  <= pf_data_d;
    out_data_q <= out_data_d;
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign occupancy     = occ_q;
  assign max_occupancy = max_q;
  assign overflow_err  = ovf_q;

`ifndef SYNTHESIS
  if (N_ENTRIES < 4 || (N_ENTRIES & (N_ENTRIES - 1)) != 0) begin : g_param_check
    $error("ofs_plat_axi_mem_rd_rsp_buffer: N_ENTRIES must be a power of 2 and >= 4");
  end

  always_ff @(posedge clk) begin
    if (reset_n && drop && !ovf_q)
      $warning("ofs_plat_axi_mem_rd_rsp_buffer: response beat dropped, credit contract violated");
  end
`endif

endmodule

// File: tb/tb_ofs_plat_axi_mem_rd_rsp_buffer.sv
// Bench for the read-response buffer: directed scenarios plus a randomized
// stream, checked against a queue model with a fixed two-edge visibility rule.
module tb_ofs_plat_axi_mem_rd_rsp_buffer;

  localparam int N = 8;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [3:0]   occupancy;
  logic [3:0]   max_occupancy;
  logic         overflow_err;

  int total = 0;
  int bad   = 0;

  ofs_plat_axi_mem_rd_rsp_buffer #(.N_ENTRIES(N), .N_DATA_BITS(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .max_occupancy(max_occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: held beats in arrival order, each stamped with the edge
  // that sampled it; the oldest beat is visible once two edges have passed.
  typedef struct {
    logic [W-1:0] data;
    int unsigned  stamp;
  } beat_t;

  beat_t        q[$];
  int unsigned  edge_cnt = 0;
  logic         m_ov = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_cnt = 0;
  int           m_max = 0;
  logic         m_ovf = 1'b0;

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_data = '0; m_cnt = 0; m_max = 0; m_ovf = 1'b0;
  endtask

  task automatic tick();
    logic  fire, acc;
    beat_t b;
    fire = m_ov && out_ready;
    acc  = in_valid && (q.size() < N || fire);
    b.data = in_data;
    @(posedge clk);
    edge_cnt++;
    if (fire) void'(q.pop_front());
    if (acc) begin
      b.stamp = edge_cnt;
      q.push_back(b);
    end
    if (in_valid && !acc) m_ovf = 1'b1;
    m_cnt = q.size();
    if (m_cnt > m_max) m_max = m_cnt;
    m_ov   = (q.size() > 0) && (q[0].stamp + 2 <= edge_cnt);
    m_data = m_ov ? q[0].data : '0;
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    total++; if (max_occupancy !== 4'd0) begin bad++; $display("FAIL reset_max got=%0d exp=0", max_occupancy); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    push(16'h00A5);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_e1_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_e1_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_e2_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 16'h00A5) begin bad++; $display("FAIL single_data got=%h exp=00a5", out_data); end
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_e3_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL single_e3_occ got=%0d exp=0", occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream_stalled();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(W'(i));
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL stream_occ got=%0d exp=8", occupancy); end
    total++; if (max_occupancy !== 4'd8) begin bad++; $display("FAIL stream_max got=%0d exp=8", max_occupancy); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL stream_ovf got=%b exp=0", overflow_err); end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        bad++; $display("FAIL stream_drain valid=%b data=%h exp_data=%h", out_valid, out_data, W'(i));
      end
      tick();
    end
    total++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
      bad++; $display("FAIL stream_empty valid=%b occ=%0d exp 0/0", out_valid, occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_simultaneous();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(W'(i));
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL fullsim_fill got=%0d exp=8", occupancy); end
    out_ready = 1'b1;
    push(16'h0009);
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL fullsim_occ got=%0d exp=8", occupancy); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL fullsim_ovf got=%b exp=0", overflow_err); end
    for (int i = 2; i <= 9; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        bad++; $display("FAIL fullsim_drain valid=%b data=%h exp_data=%h", out_valid, out_data, W'(i));
      end
      tick();
    end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL fullsim_empty got=%0d exp=0", occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(W'(i));
    push(16'h00FF);
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow_err); end
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL ovf_occ got=%0d exp=8", occupancy); end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        bad++; $display("FAIL ovf_drain valid=%b data=%h exp_data=%h", out_valid, out_data, W'(i));
      end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_extra_beat valid=%b data=%h exp_valid=0", out_valid, out_data); end
    tick();
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(W'(16'h0040 + i));
    total++; if (occupancy !== 4'd5 || out_valid !== 1'b1) begin
      bad++; $display("FAIL arst_pre occ=%0d valid=%b exp 5/1", occupancy, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid_drop got=%b exp=0", out_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL arst_occ got=%0d exp=0", occupancy); end
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    total++; if (occupancy !== 4'd0 || max_occupancy !== 4'd0) begin
      bad++; $display("FAIL arst_release occ=%0d max=%0d exp 0/0", occupancy, max_occupancy);
    end
    out_ready = 1'b1;
    push(16'h1234);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_early got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      bad++; $display("FAIL arst_new_beat valid=%b data=%h exp 1/1234", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int           sent, rcvd, cyc;
    logic [W-1:0] rx_next;
    do_reset();
    sent = 0; rcvd = 0; cyc = 0; rx_next = 16'd1;
    while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
      total++; if (out_valid !== m_ov) begin
        bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ov);
      end
      if (m_ov) begin
        total++; if (out_data !== m_data) begin
          bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, m_data);
        end
      end
      total++; if (occupancy !== 4'(m_cnt) || max_occupancy !== 4'(m_max)) begin
        bad++; $display("FAIL rand_occ cyc=%0d occ=%0d max=%0d exp=%0d/%0d", cyc, occupancy, max_occupancy, m_cnt, m_max);
      end
      out_ready = ($urandom_range(9) < 3);
      in_valid  = (sent < 1000) && ($urandom_range(1) == 1) && (m_cnt < N);
      in_data   = W'(sent + 1);
      if (out_valid && out_ready) begin
        total++; if (out_data !== rx_next) begin
          bad++; $display("FAIL rand_order got=%h exp=%h", out_data, rx_next);
        end
        rx_next++;
        rcvd++;
      end
      if (in_valid) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (rcvd != 1000) begin bad++; $display("FAIL rand_count got=%0d exp=1000 (cycle budget)", rcvd); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b exp=0", overflow_err); end
    total++; if (max_occupancy > 4'd8) begin bad++; $display("FAIL rand_max got=%0d exp<=8", max_occupancy); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_stream_stalled();
    test_full_simultaneous();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
